// File: rtl/sb_tx_pkg.sv
// Shared types and default sizing for the sideband transmit serializer.
package sb_tx_pkg;

    localparam int unsigned SB_PKT_W  = 64;
    localparam int unsigned SB_GAP_UI = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sb_tx_hold_reg.sv
// One-entry hold buffer for a packet waiting behind the active shifter.
module sb_tx_hold_reg
    import sb_tx_pkg::*;
#(
    parameter int unsigned W = SB_PKT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic [W-1:0] i_data,
    input  logic         i_pattern,
    output logic [W-1:0] o_data,
    output logic         o_pattern,
    output logic         o_full
);

    logic [W-1:0] data_q;
    logic         pat_q;
    logic         full_q;
    logic         full_d;

    // A load in the same edge as an unload refills the entry, so it stays full.
    always_comb begin
        full_d = full_q;
        if (i_load) begin
            full_d = 1'b1;
        end else if (i_unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
            pat_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (i_load) begin
                data_q <= i_data;
                pat_q  <= i_pattern;
            end
        end
    end

    assign o_data    = data_q;
    assign o_pattern = pat_q;
    assign o_full    = full_q;

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband packet serializer: LSB-first shift-out with forwarded-clock enable,
// idle gap after normal packets and gapless streaming of training patterns.
module sb_tx_serializer
    import sb_tx_pkg::*;
#(
    parameter int unsigned PKT_W  = SB_PKT_W,
    parameter int unsigned GAP_UI = SB_GAP_UI
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_pattern_mode,
    input  logic [PKT_W-1:0] i_data,
    output logic             o_ready,
    output logic             o_txdat_sb,
    output logic             o_txclk_en,
    output logic             o_ser_done,
    output logic             o_busy
);

    localparam int unsigned UI_W  = $clog2(PKT_W);
    localparam int unsigned GAP_W = $clog2(GAP_UI);
    localparam logic [UI_W-1:0]  UI_LAST  = UI_W'(PKT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_UI - 1);

    sb_state_e        state_q, state_d;
    logic [PKT_W-1:0] sh_q, sh_d;
    logic             pat_q, pat_d;
    logic [UI_W-1:0]  ui_q, ui_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             txdat_q, txdat_d;
    logic             txen_q, txen_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             hold_load;
    logic             hold_unload;
    logic             hold_full;
    logic             hold_full_d;
    logic [PKT_W-1:0] hold_data;
    logic             hold_pat;

    assign accept  = i_valid & ~hold_full;
    assign o_ready = ~hold_full;

    sb_tx_hold_reg #(
        .W (PKT_W)
    ) u_hold (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (hold_load),
        .i_unload  (hold_unload),
        .i_data    (i_data),
        .i_pattern (i_pattern_mode),
        .o_data    (hold_data),
        .o_pattern (hold_pat),
        .o_full    (hold_full)
    );

    // Next-state, shifter/counter update and registered output values.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        pat_d       = pat_q;
        ui_d        = ui_q;
        gap_d       = gap_q;
        txdat_d     = 1'b0;
        txen_d      = 1'b0;
        done_d      = 1'b0;
        hold_load   = accept;
        hold_unload = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full) begin
                    sh_d        = hold_data;
                    pat_d       = hold_pat;
                    hold_unload = 1'b1;
                    ui_d        = '0;
                    state_d     = ST_SHIFT;
                end else if (accept) begin
                    // Empty hold buffer: the word goes straight into the shifter.
                    sh_d      = i_data;
                    pat_d     = i_pattern_mode;
                    hold_load = 1'b0;
                    ui_d      = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                txdat_d = sh_q[0];
                txen_d  = 1'b1;
                sh_d    = sh_q >> 1;
                ui_d    = ui_q + UI_W'(1);
                if (ui_q == UI_LAST) begin
                    done_d = 1'b1;
                    ui_d   = '0;
                    if (!pat_q) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else if (hold_full) begin
                        sh_d        = hold_data;
                        pat_d       = hold_pat;
                        hold_unload = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (hold_full) begin
                        sh_d        = hold_data;
                        pat_d       = hold_pat;
                        hold_unload = 1'b1;
                        ui_d        = '0;
                        state_d     = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hold_full_d = hold_load | (hold_full & ~hold_unload);
        busy_d      = (state_d != ST_IDLE) | hold_full_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            pat_q   <= 1'b0;
            ui_q    <= '0;
            gap_q   <= '0;
            txdat_q <= 1'b0;
            txen_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            ui_q    <= ui_d;
            gap_q   <= gap_d;
            txdat_q <= txdat_d;
            txen_q  <= txen_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_txdat_sb = txdat_q;
    assign o_txclk_en = txen_q;
    assign o_ser_done = done_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed self-checking bench for sb_tx_serializer.
module tb_sb_tx_serializer;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic         valid;
    logic         pmode;
    logic [W-1:0] data;
    logic         ready;
    logic         txdat;
    logic         txen;
    logic         done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         pat;
        int           gap;
    } vec_t;

    vec_t vecs [5];

    sb_tx_serializer #(
        .PKT_W  (64),
        .GAP_UI (32)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (valid),
        .i_pattern_mode (pmode),
        .i_data         (data),
        .o_ready        (ready),
        .o_txdat_sb     (txdat),
        .o_txclk_en     (txen),
        .o_ser_done     (done),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int t, input logic edat, input logic een,
                           input logic edone, input logic ebusy);
        chk({nm, ".dat"},  t, 64'(txdat), 64'(edat));
        chk({nm, ".en"},   t, 64'(txen),  64'(een));
        chk({nm, ".done"}, t, 64'(done),  64'(edone));
        chk({nm, ".busy"}, t, 64'(busy),  64'(ebusy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic         edat;
        logic         ecl;
        int           n_en;
        int           n_done;

        vecs[0] = '{64'hA5A5_0000_FFFF_1234, 1'b0, 32};
        vecs[1] = '{64'h8000_0000_0000_0001, 1'b0, 32};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 1'b1, 0};
        vecs[4] = '{64'h0000_0000_0000_0000, 1'b0, 32};

        rst   = 1'b1;
        valid = 1'b0;
        pmode = 1'b0;
        data  = '0;

        // Reset state
        #1;
        chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.ready", 0, 64'(ready), 64'd1);
        step();
        step();
        rst = 1'b0;
        step();
        chk_out("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single packets from IDLE, table driven
        for (int i = 0; i < 5; i++) begin
            d     = vecs[i].data;
            data  = d;
            pmode = vecs[i].pat;
            valid = 1'b1;
            step();
            valid = 1'b0;
            pmode = 1'b0;
            chk("single.en0",    0, 64'(txen),  64'd0);
            chk("single.busy0",  0, 64'(busy),  64'd1);
            chk("single.ready0", 0, 64'(ready), 64'd1);
            for (int t = 1; t <= 64 + vecs[i].gap; t++) begin
                step();
                edat = (t <= 64) ? d[t-1] : 1'b0;
                chk_out("single", t, edat, t <= 64, t == 64, t < 64 + vecs[i].gap);
            end
            step();
            chk_out("single.idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back packets plus a word held on i_valid while the hold buffer is full
        a = 64'h0F0F_1234_DEAD_BEEF;
        b = 64'hC3C3_5A5A_0001_8000;
        c = 64'h7E57_C0DE_FACE_0042;
        data  = a;
        valid = 1'b1;
        step();
        data = b;
        for (int t = 1; t <= 288; t++) begin
            step();
            if (t <= 64)       edat = a[t-1];
            else if (t <= 96)  edat = 1'b0;
            else if (t <= 160) edat = b[t-97];
            else if (t <= 192) edat = 1'b0;
            else if (t <= 256) edat = c[t-193];
            else               edat = 1'b0;
            ecl = (t <= 64) || (t >= 97 && t <= 160) || (t >= 193 && t <= 256);
            chk_out("b2b", t, edat, ecl, t == 64 || t == 160 || t == 256, t < 288);
            chk("b2b.ready", t, 64'(ready), 64'((t == 96) || (t >= 192)));
            if (t == 1)  data = c;
            if (t == 97) valid = 1'b0;
        end
        step();
        chk_out("b2b.idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous training pattern: no gap, clock enable never drops
        data  = 64'hAAAA_AAAA_AAAA_AAAA;
        pmode = 1'b1;
        valid = 1'b1;
        step();
        for (int t = 1; t <= 257; t++) begin
            step();
            edat = (t <= 256) && (t % 2 == 0);
            chk_out("pattern", t, edat, t <= 256, (t <= 256) && (t % 64 == 0), t < 256);
            if (t == 130) begin
                valid = 1'b0;
                pmode = 1'b0;
            end
        end

        // Reset at bit 30 with the hold buffer full
        data  = a;
        valid = 1'b1;
        step();
        data = b;
        step();
        valid = 1'b0;
        for (int t = 2; t <= 31; t++) step();
        chk("rst.bit30", 31, 64'(txdat), 64'(a[30]));
        chk("rst.ready_pre", 31, 64'(ready), 64'd0);
        rst = 1'b1;
        #1;
        chk_out("rst.async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.ready", 0, 64'(ready), 64'd1);
        step();
        rst = 1'b0;
        n_en   = 0;
        n_done = 0;
        for (int t = 0; t < 120; t++) begin
            step();
            if (txen === 1'b1) n_en++;
            if (done === 1'b1) n_done++;
        end
        chk("rst.no_en",   0, 64'(n_en),   64'd0);
        chk("rst.no_done", 0, 64'(n_done), 64'd0);
        chk("rst.busy",    0, 64'(busy),   64'd0);
        chk("rst.ready2",  0, 64'(ready),  64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_tx_serializer.md
SB_TX_SERIALIZER -- requirements
Module: sb_tx_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter PKT_W, default 64, SHALL set the packet width in UI.
REQ-003 Parameter GAP_UI, default 32, SHALL set the idle gap in UI between non-pattern packets.
REQ-004 Port i_clk, input, 1, SHALL be the sideband serial clock; all logic runs on its rising edge.
REQ-005 Port i_rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port i_valid, input, 1, SHALL flag i_data as a packet offered for transmission (encoder pattern_valid OR packet_valid).
REQ-007 Port i_pattern_mode, input, 1, SHALL mark the offered word as a training pattern, sampled with i_data.
REQ-008 Port i_data, input, PKT_W, SHALL carry the final encoded packet.
REQ-009 Port o_ready, output, 1, SHALL indicate the block can accept a word this cycle.
REQ-010 Port o_txdat_sb, output, 1, SHALL carry serial data, registered.
REQ-011 Port o_txclk_en, output, 1, SHALL enable the forwarded sideband clock, registered, high only while data UI are driven.
REQ-012 Port o_ser_done, output, 1, SHALL pulse for one cycle per completed packet.
REQ-013 Port o_busy, output, 1, SHALL be high whenever state is not IDLE or the hold buffer is full.

Function
REQ-014 A word SHALL be accepted on a rising edge where i_valid and o_ready are both 1; i_valid without o_ready SHALL be ignored, not queued.
REQ-015 Storage SHALL be one shift register plus one 1-entry hold buffer; o_ready SHALL equal NOT hold_full.
REQ-016 States SHALL be IDLE, SHIFT and GAP.
REQ-017 IDLE: if the hold buffer is full or a word is accepted this cycle, the block SHALL load the shifter and go to SHIFT; the word bypasses the hold buffer when it is empty.
REQ-018 Accept at edge N from IDLE with an empty hold buffer: bit 0 SHALL appear on o_txdat_sb in cycle N+1, and bit k in cycle N+1+k.
REQ-019 Bits SHALL be sent LSB first; o_txclk_en SHALL be 1 for exactly PKT_W consecutive cycles per packet.
REQ-020 o_ser_done SHALL be high in the cycle the last bit (bit PKT_W-1) is driven, that is cycle N+64 for REQ-018 timing.
REQ-021 SHIFT->GAP after bit PKT_W-1 if that packet's pattern flag is 0; GAP SHALL drive o_txdat_sb=0 and o_txclk_en=0 for exactly GAP_UI cycles.
REQ-022 GAP exit SHALL go to SHIFT, with bit 0 in the next cycle, if the hold buffer is full, and to IDLE otherwise.
REQ-023 SHIFT with pattern flag 1 SHALL skip GAP; if the hold buffer is full, the next bit 0 SHALL follow bit 63 in the next cycle with o_txclk_en kept high, otherwise the next state is IDLE.
REQ-024 Simultaneous hold-to-shifter transfer and new accept SHALL be legal: the hold buffer is refilled in the same edge and stays full.
REQ-025 The UI counter SHALL be $clog2(PKT_W) bits and wrap from PKT_W-1 to 0 without a spare cycle; the gap counter SHALL be $clog2(GAP_UI) bits.
REQ-026 In IDLE, o_txdat_sb SHALL be 0 and o_txclk_en SHALL be 0.

Reset
REQ-027 While i_rst=1: state=IDLE, hold empty, counters 0, o_txdat_sb=0, o_txclk_en=0, o_ser_done=0, o_busy=0, o_ready=1.
REQ-028 Reset mid-packet SHALL abort immediately; partial and held packets SHALL be discarded and no o_ser_done issued.

Structure
REQ-029 Package sb_tx_pkg SHALL hold the state enum, SB_PKT_W=64 and SB_GAP_UI=32.
REQ-030 The hold buffer SHALL be sub-module sb_tx_hold_reg (data, pattern flag, full bit; load/unload ports).

Verification
REQ-031 Single packet 64'hA5A5_0000_FFFF_1234, pattern 0 -> bits LSB-first in cycles N+1..N+64, done pulse at N+64, 32 gap cycles, then IDLE.
REQ-032 Two back-to-back non-pattern packets -> second accepted at N+1 (o_ready 0 until refill), its bit 0 at N+97.
REQ-033 Pattern 64'hAAAA_AAAA_AAAA_AAAA streamed continuously in pattern mode -> unbroken 1010... on o_txdat_sb, o_txclk_en never drops, done every 64 cycles.
REQ-034 i_valid held while hold full -> no capture, o_ready=0, the word is sent once after o_ready returns.
REQ-035 i_rst pulsed at bit 30 with hold full -> outputs 0 within the reset cycle, no done, IDLE afterwards, o_ready=1.
